// File: rtl/vu_dmem_arb.sv
// Round-robin arbiter merging the vector (128-bit line) and microthread (64-bit doubleword)
// request streams onto one 128-bit data-cache port; responses are routed back by extended tag.
module vu_dmem_arb (
   input  logic         clk,
   input  logic         reset,
   input  logic [27:0]  dmem_req_vec_addr,
   input  logic [3:0]   dmem_req_vec_op,
   input  logic [127:0] dmem_req_vec_data,
   input  logic [15:0]  dmem_req_vec_wmask,
   input  logic [11:0]  dmem_req_vec_tag,
   input  logic         dmem_req_vec_val,
   output logic         dmem_req_vec_rdy,
   output logic         dmem_resp_vec_val,
   output logic [11:0]  dmem_resp_vec_tag,
   output logic [127:0] dmem_resp_vec_data,
   input  logic [29:0]  dmem_req_ut_addr,
   input  logic [3:0]   dmem_req_ut_op,
   input  logic [63:0]  dmem_req_ut_data,
   input  logic [7:0]   dmem_req_ut_wmask,
   input  logic [11:0]  dmem_req_ut_tag,
   input  logic         dmem_req_ut_val,
   output logic         dmem_req_ut_rdy,
   output logic         dmem_resp_ut_val,
   output logic [11:0]  dmem_resp_ut_tag,
   output logic [63:0]  dmem_resp_ut_data,
   output logic [27:0]  cache_req_addr,
   output logic [3:0]   cache_req_op,
   output logic [127:0] cache_req_data,
   output logic [15:0]  cache_req_wmask,
   output logic [13:0]  cache_req_tag,
   output logic         cache_req_val,
   input  logic         cache_req_rdy,
   input  logic         cache_resp_val,
   input  logic [13:0]  cache_resp_tag,
   input  logic [127:0] cache_resp_data
);

   logic         full_r;
   logic         prio_r;
   logic [27:0]  req_addr_r;
   logic [3:0]   req_op_r;
   logic [127:0] req_data_r;
   logic [15:0]  req_wmask_r;
   logic [13:0]  req_tag_r;
   logic         resp_val_r;
   logic [13:0]  resp_tag_r;
   logic [127:0] resp_data_r;

   logic         can_accept_s;
   logic         gnt_vec_s;
   logic         gnt_ut_s;
   logic         accept_s;
   logic         ut_half_s;
   logic [27:0]  nxt_addr_s;
   logic [3:0]   nxt_op_s;
   logic [127:0] nxt_data_s;
   logic [15:0]  nxt_wmask_s;
   logic [13:0]  nxt_tag_s;
   logic         unused_s;

   // The ut address MSB is required to be zero at the source, so it is dropped.
   assign unused_s     = dmem_req_ut_addr[29];
   assign ut_half_s    = dmem_req_ut_addr[0];
   assign can_accept_s = !full_r || cache_req_rdy;
   assign gnt_vec_s    = dmem_req_vec_val && (!dmem_req_ut_val || !prio_r);
   assign gnt_ut_s     = dmem_req_ut_val && (!dmem_req_vec_val || prio_r);
   assign accept_s     = (gnt_vec_s || gnt_ut_s) && can_accept_s && !reset;

   assign dmem_req_vec_rdy = gnt_vec_s && can_accept_s && !reset;
   assign dmem_req_ut_rdy  = gnt_ut_s && can_accept_s && !reset;

   // Format the granted request into the cache-port payload.
   always_comb begin
      nxt_addr_s  = dmem_req_vec_addr;
      nxt_op_s    = dmem_req_vec_op;
      nxt_data_s  = dmem_req_vec_data;
      nxt_wmask_s = dmem_req_vec_wmask;
      nxt_tag_s   = {1'b0, 1'b0, dmem_req_vec_tag};
      if (gnt_ut_s) begin
         nxt_addr_s  = dmem_req_ut_addr[28:1];
         nxt_op_s    = dmem_req_ut_op;
         nxt_data_s  = {dmem_req_ut_data, dmem_req_ut_data};
         nxt_wmask_s = ut_half_s ? {dmem_req_ut_wmask, 8'h00} : {8'h00, dmem_req_ut_wmask};
         nxt_tag_s   = {1'b1, ut_half_s, dmem_req_ut_tag};
      end else begin
         nxt_addr_s  = dmem_req_vec_addr;
      end
   end

   // Output-stage occupancy and round-robin pointer.
   always_ff @(posedge clk) begin
      if (reset) begin
         full_r <= 1'b0;
         prio_r <= 1'b0;
      end else if (accept_s) begin
         full_r <= 1'b1;
         prio_r <= gnt_vec_s;
      end else if (cache_req_rdy) begin
         full_r <= 1'b0;
      end
   end

   // Output-stage payload; contents are don't-care while the stage is empty.
   always_ff @(posedge clk) begin
      if (accept_s) begin
         req_addr_r  <= nxt_addr_s;
         req_op_r    <= nxt_op_s;
         req_data_r  <= nxt_data_s;
         req_wmask_r <= nxt_wmask_s;
         req_tag_r   <= nxt_tag_s;
      end
   end

   // Response valid register; a response in the reset cycle is dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         resp_val_r <= 1'b0;
      end else begin
         resp_val_r <= cache_resp_val;
      end
   end

   // Response tag/data capture.
   always_ff @(posedge clk) begin
      resp_tag_r  <= cache_resp_tag;
      resp_data_r <= cache_resp_data;
   end

   assign cache_req_val   = full_r;
   assign cache_req_addr  = req_addr_r;
   assign cache_req_op    = req_op_r;
   assign cache_req_data  = req_data_r;
   assign cache_req_wmask = req_wmask_r;
   assign cache_req_tag   = req_tag_r;

   // Tag bit 13 selects the stream, bit 12 the doubleword half for ut.
   assign dmem_resp_vec_val  = resp_val_r && !resp_tag_r[13];
   assign dmem_resp_ut_val   = resp_val_r && resp_tag_r[13];
   assign dmem_resp_vec_tag  = resp_tag_r[11:0];
   assign dmem_resp_ut_tag   = resp_tag_r[11:0];
   assign dmem_resp_vec_data = resp_data_r;
   assign dmem_resp_ut_data  = resp_tag_r[12] ? resp_data_r[127:64] : resp_data_r[63:0];

endmodule

// File: tb/tb_vu_dmem_arb.sv
// Directed self-checking bench for vu_dmem_arb: request formatting, round-robin,
// backpressure, response routing and reset.
module tb_vu_dmem_arb;

   logic         clk = 1'b0;
   logic         reset;
   logic [27:0]  dmem_req_vec_addr;
   logic [3:0]   dmem_req_vec_op;
   logic [127:0] dmem_req_vec_data;
   logic [15:0]  dmem_req_vec_wmask;
   logic [11:0]  dmem_req_vec_tag;
   logic         dmem_req_vec_val;
   logic         dmem_req_vec_rdy;
   logic         dmem_resp_vec_val;
   logic [11:0]  dmem_resp_vec_tag;
   logic [127:0] dmem_resp_vec_data;
   logic [29:0]  dmem_req_ut_addr;
   logic [3:0]   dmem_req_ut_op;
   logic [63:0]  dmem_req_ut_data;
   logic [7:0]   dmem_req_ut_wmask;
   logic [11:0]  dmem_req_ut_tag;
   logic         dmem_req_ut_val;
   logic         dmem_req_ut_rdy;
   logic         dmem_resp_ut_val;
   logic [11:0]  dmem_resp_ut_tag;
   logic [63:0]  dmem_resp_ut_data;
   logic [27:0]  cache_req_addr;
   logic [3:0]   cache_req_op;
   logic [127:0] cache_req_data;
   logic [15:0]  cache_req_wmask;
   logic [13:0]  cache_req_tag;
   logic         cache_req_val;
   logic         cache_req_rdy;
   logic         cache_resp_val;
   logic [13:0]  cache_resp_tag;
   logic [127:0] cache_resp_data;

   int pass_cnt = 0;
   int total_cnt = 0;

   vu_dmem_arb dut (
      .clk(clk), .reset(reset),
      .dmem_req_vec_addr(dmem_req_vec_addr), .dmem_req_vec_op(dmem_req_vec_op),
      .dmem_req_vec_data(dmem_req_vec_data), .dmem_req_vec_wmask(dmem_req_vec_wmask),
      .dmem_req_vec_tag(dmem_req_vec_tag), .dmem_req_vec_val(dmem_req_vec_val),
      .dmem_req_vec_rdy(dmem_req_vec_rdy), .dmem_resp_vec_val(dmem_resp_vec_val),
      .dmem_resp_vec_tag(dmem_resp_vec_tag), .dmem_resp_vec_data(dmem_resp_vec_data),
      .dmem_req_ut_addr(dmem_req_ut_addr), .dmem_req_ut_op(dmem_req_ut_op),
      .dmem_req_ut_data(dmem_req_ut_data), .dmem_req_ut_wmask(dmem_req_ut_wmask),
      .dmem_req_ut_tag(dmem_req_ut_tag), .dmem_req_ut_val(dmem_req_ut_val),
      .dmem_req_ut_rdy(dmem_req_ut_rdy), .dmem_resp_ut_val(dmem_resp_ut_val),
      .dmem_resp_ut_tag(dmem_resp_ut_tag), .dmem_resp_ut_data(dmem_resp_ut_data),
      .cache_req_addr(cache_req_addr), .cache_req_op(cache_req_op),
      .cache_req_data(cache_req_data), .cache_req_wmask(cache_req_wmask),
      .cache_req_tag(cache_req_tag), .cache_req_val(cache_req_val),
      .cache_req_rdy(cache_req_rdy), .cache_resp_val(cache_resp_val),
      .cache_resp_tag(cache_resp_tag), .cache_resp_data(cache_resp_data)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      dmem_req_vec_addr  = 28'h0;
      dmem_req_vec_op    = 4'h0;
      dmem_req_vec_data  = 128'h0;
      dmem_req_vec_wmask = 16'h0;
      dmem_req_vec_tag   = 12'h0;
      dmem_req_vec_val   = 1'b0;
      dmem_req_ut_addr   = 30'h0;
      dmem_req_ut_op     = 4'h0;
      dmem_req_ut_data   = 64'h0;
      dmem_req_ut_wmask  = 8'h0;
      dmem_req_ut_tag    = 12'h0;
      dmem_req_ut_val    = 1'b0;
      cache_req_rdy      = 1'b1;
      cache_resp_val     = 1'b0;
      cache_resp_tag     = 14'h0;
      cache_resp_data    = 128'h0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      dmem_req_vec_val = 1'b1;
      dmem_req_ut_val  = 1'b1;
      cache_resp_val   = 1'b1;
      tick();
      tick();
      total_cnt++;
      if (cache_req_val !== 1'b0) $display("FAIL reset_req_val got %b exp 0", cache_req_val);
      else pass_cnt++;
      total_cnt++;
      if ({dmem_resp_vec_val, dmem_resp_ut_val} !== 2'b00)
         $display("FAIL reset_resp_val got %b exp 00", {dmem_resp_vec_val, dmem_resp_ut_val});
      else pass_cnt++;
      total_cnt++;
      if ({dmem_req_vec_rdy, dmem_req_ut_rdy} !== 2'b00)
         $display("FAIL reset_rdy got %b exp 00", {dmem_req_vec_rdy, dmem_req_ut_rdy});
      else pass_cnt++;
      idle_inputs();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_vec_single();
      dmem_req_vec_addr  = 28'h123;
      dmem_req_vec_tag   = 12'h005;
      dmem_req_vec_op    = 4'h1;
      dmem_req_vec_data  = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
      dmem_req_vec_wmask = 16'hF0F0;
      dmem_req_vec_val   = 1'b1;
      #1;
      total_cnt++;
      if ({dmem_req_vec_rdy, dmem_req_ut_rdy} !== 2'b10)
         $display("FAIL vec_rdy got %b exp 10", {dmem_req_vec_rdy, dmem_req_ut_rdy});
      else pass_cnt++;
      tick();
      dmem_req_vec_val = 1'b0;
      #1;
      total_cnt++;
      if ({cache_req_val, cache_req_addr, cache_req_tag, cache_req_op} !== {1'b1, 28'h123, 14'h005, 4'h1})
         $display("FAIL vec_req got %b %h %h %h exp 1 0000123 0005 1",
                  cache_req_val, cache_req_addr, cache_req_tag, cache_req_op);
      else pass_cnt++;
      total_cnt++;
      if ({cache_req_data, cache_req_wmask} !== {128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF, 16'hF0F0})
         $display("FAIL vec_payload got %h %h", cache_req_data, cache_req_wmask);
      else pass_cnt++;
      total_cnt++;
      if (dmem_req_vec_rdy !== 1'b0) $display("FAIL vec_rdy_pulse got %b exp 0", dmem_req_vec_rdy);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (cache_req_val !== 1'b0) $display("FAIL vec_drain got %b exp 0", cache_req_val);
      else pass_cnt++;
   endtask

   task automatic test_ut_format();
      dmem_req_ut_addr  = 30'h247;
      dmem_req_ut_wmask = 8'hFF;
      dmem_req_ut_data  = 64'hA5A5_0123_4567_89AB;
      dmem_req_ut_tag   = 12'h03C;
      dmem_req_ut_op    = 4'h2;
      dmem_req_ut_val   = 1'b1;
      #1;
      total_cnt++;
      if ({dmem_req_vec_rdy, dmem_req_ut_rdy} !== 2'b01)
         $display("FAIL ut_rdy got %b exp 01", {dmem_req_vec_rdy, dmem_req_ut_rdy});
      else pass_cnt++;
      tick();
      total_cnt++;
      if ({cache_req_val, cache_req_addr, cache_req_wmask, cache_req_tag, cache_req_op}
          !== {1'b1, 28'h123, 16'hFF00, 14'h303C, 4'h2})
         $display("FAIL ut_odd_req got %b %h %h %h %h exp 1 0000123 ff00 303c 2",
                  cache_req_val, cache_req_addr, cache_req_wmask, cache_req_tag, cache_req_op);
      else pass_cnt++;
      total_cnt++;
      if (cache_req_data !== 128'hA5A5_0123_4567_89AB_A5A5_0123_4567_89AB)
         $display("FAIL ut_odd_data got %h", cache_req_data);
      else pass_cnt++;
      dmem_req_ut_addr  = 30'h246;
      dmem_req_ut_wmask = 8'h0F;
      dmem_req_ut_tag   = 12'h0A1;
      tick();
      dmem_req_ut_val = 1'b0;
      total_cnt++;
      if ({cache_req_val, cache_req_addr, cache_req_wmask, cache_req_tag}
          !== {1'b1, 28'h123, 16'h000F, 14'h20A1})
         $display("FAIL ut_even_req got %b %h %h %h exp 1 0000123 000f 20a1",
                  cache_req_val, cache_req_addr, cache_req_wmask, cache_req_tag);
      else pass_cnt++;
      tick();
   endtask

   task automatic test_round_robin();
      dmem_req_vec_tag = 12'h011;
      dmem_req_ut_tag  = 12'h022;
      dmem_req_ut_addr = 30'h100;
      dmem_req_vec_val = 1'b1;
      dmem_req_ut_val  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         total_cnt++;
         if ({dmem_req_vec_rdy, dmem_req_ut_rdy} !== ((i % 2 == 0) ? 2'b10 : 2'b01))
            $display("FAIL rr_rdy[%0d] got %b exp %b", i, {dmem_req_vec_rdy, dmem_req_ut_rdy},
                     (i % 2 == 0) ? 2'b10 : 2'b01);
         else pass_cnt++;
         tick();
         total_cnt++;
         if ({cache_req_val, cache_req_tag} !== {1'b1, ((i % 2 == 0) ? 14'h0011 : 14'h2022)})
            $display("FAIL rr_req[%0d] got %b %h", i, cache_req_val, cache_req_tag);
         else pass_cnt++;
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_backpressure();
      cache_req_rdy     = 1'b0;
      dmem_req_vec_addr = 28'h0AA;
      dmem_req_vec_tag  = 12'h033;
      dmem_req_vec_val  = 1'b1;
      tick();
      dmem_req_vec_addr = 28'h0BB;
      dmem_req_vec_tag  = 12'h044;
      dmem_req_ut_addr  = 30'h100;
      dmem_req_ut_tag   = 12'h055;
      dmem_req_ut_val   = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         total_cnt++;
         if ({dmem_req_vec_rdy, dmem_req_ut_rdy, cache_req_val, cache_req_addr, cache_req_tag}
             !== {2'b00, 1'b1, 28'h0AA, 14'h0033})
            $display("FAIL bp_hold[%0d] got rdy %b val %b addr %h tag %h", i,
                     {dmem_req_vec_rdy, dmem_req_ut_rdy}, cache_req_val, cache_req_addr, cache_req_tag);
         else pass_cnt++;
         tick();
      end
      cache_req_rdy = 1'b1;
      #1;
      total_cnt++;
      if ({dmem_req_vec_rdy, dmem_req_ut_rdy} !== 2'b01)
         $display("FAIL bp_refill_rdy got %b exp 01", {dmem_req_vec_rdy, dmem_req_ut_rdy});
      else pass_cnt++;
      tick();
      total_cnt++;
      if ({cache_req_val, cache_req_addr, cache_req_tag} !== {1'b1, 28'h080, 14'h2055})
         $display("FAIL bp_refill_req got %b %h %h exp 1 0000080 2055",
                  cache_req_val, cache_req_addr, cache_req_tag);
      else pass_cnt++;
      dmem_req_ut_val = 1'b0;
      tick();
      dmem_req_vec_val = 1'b0;
      total_cnt++;
      if ({cache_req_val, cache_req_addr, cache_req_tag} !== {1'b1, 28'h0BB, 14'h0044})
         $display("FAIL bp_next_req got %b %h %h exp 1 00000bb 0044",
                  cache_req_val, cache_req_addr, cache_req_tag);
      else pass_cnt++;
      tick();
   endtask

   task automatic test_response();
      cache_resp_val  = 1'b1;
      cache_resp_tag  = 14'h30AB;
      cache_resp_data = 128'hDEAD_BEEF_CAFE_F00D_1234_5678_9ABC_DEF0;
      tick();
      total_cnt++;
      if ({dmem_resp_ut_val, dmem_resp_vec_val, dmem_resp_ut_tag, dmem_resp_ut_data}
          !== {2'b10, 12'h0AB, 64'hDEAD_BEEF_CAFE_F00D})
         $display("FAIL resp_ut_hi got %b%b %h %h", dmem_resp_ut_val, dmem_resp_vec_val,
                  dmem_resp_ut_tag, dmem_resp_ut_data);
      else pass_cnt++;
      cache_resp_tag = 14'h2055;
      tick();
      total_cnt++;
      if ({dmem_resp_ut_val, dmem_resp_ut_tag, dmem_resp_ut_data} !== {1'b1, 12'h055, 64'h1234_5678_9ABC_DEF0})
         $display("FAIL resp_ut_lo got %b %h %h", dmem_resp_ut_val, dmem_resp_ut_tag, dmem_resp_ut_data);
      else pass_cnt++;
      cache_resp_tag = 14'h00AB;
      tick();
      cache_resp_val = 1'b0;
      total_cnt++;
      if ({dmem_resp_vec_val, dmem_resp_ut_val, dmem_resp_vec_tag, dmem_resp_vec_data}
          !== {2'b10, 12'h0AB, 128'hDEAD_BEEF_CAFE_F00D_1234_5678_9ABC_DEF0})
         $display("FAIL resp_vec got %b%b %h %h", dmem_resp_vec_val, dmem_resp_ut_val,
                  dmem_resp_vec_tag, dmem_resp_vec_data);
      else pass_cnt++;
      tick();
      total_cnt++;
      if ({dmem_resp_vec_val, dmem_resp_ut_val} !== 2'b00)
         $display("FAIL resp_idle got %b exp 00", {dmem_resp_vec_val, dmem_resp_ut_val});
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      cache_req_rdy    = 1'b0;
      dmem_req_vec_tag = 12'h077;
      dmem_req_vec_val = 1'b1;
      tick();
      dmem_req_vec_val = 1'b0;
      reset            = 1'b1;
      cache_resp_val   = 1'b1;
      cache_resp_tag   = 14'h00AB;
      tick();
      reset          = 1'b0;
      cache_resp_val = 1'b0;
      cache_req_rdy  = 1'b1;
      total_cnt++;
      if ({cache_req_val, dmem_resp_vec_val, dmem_resp_ut_val} !== 3'b000)
         $display("FAIL rst_mid_vals got %b exp 000", {cache_req_val, dmem_resp_vec_val, dmem_resp_ut_val});
      else pass_cnt++;
      dmem_req_vec_val = 1'b1;
      dmem_req_ut_val  = 1'b1;
      #1;
      total_cnt++;
      if ({dmem_req_vec_rdy, dmem_req_ut_rdy} !== 2'b10)
         $display("FAIL rst_mid_prio got %b exp 10", {dmem_req_vec_rdy, dmem_req_ut_rdy});
      else pass_cnt++;
      tick();
      idle_inputs();
      total_cnt++;
      if ({cache_req_val, cache_req_tag} !== {1'b1, 14'h0077})
         $display("FAIL rst_mid_req got %b %h exp 1 0077", cache_req_val, cache_req_tag);
      else pass_cnt++;
      tick();
   endtask

   initial begin
      test_reset();
      test_vec_single();
      test_ut_format();
      test_round_robin();
      test_backpressure();
      test_response();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
